// File: rtl/nrs_cinit_scheduler_if.sv
// nrs_cinit_scheduler_if
//   Bundles the control, cinit-datapath and Gold-generator handshake signals
//   of the NRS cinit scheduler.
//   slave  : scheduler side (consumes starts/strobes, drives run/ns/loads)
//   master : environment side (control top, cinit datapath, Gold generator)
//   Signals:
//     sf_start     subframe start strobe          sf_num     subframe 0..9
//     nrs_subframe subframe carries NRS           cinit_done cinit ready strobe
//     gold_ready   Gold generator can accept      run        cinit start pulse
//     ns           slot number 0..19              l_sel      0: l=5, 1: l=6
//     gold_load    Gold latch strobe              sym_idx    NRS symbol 0..3
//     busy         sequence in progress           sf_done    four loads done
//     err          overrun / bad sf_num / timeout
interface nrs_cinit_scheduler_if;
    logic       sf_start;
    logic [3:0] sf_num;
    logic       nrs_subframe;
    logic       cinit_done;
    logic       gold_ready;
    logic       run;
    logic [4:0] ns;
    logic       l_sel;
    logic       gold_load;
    logic [1:0] sym_idx;
    logic       busy;
    logic       sf_done;
    logic       err;

    modport slave (
        input  sf_start, sf_num, nrs_subframe, cinit_done, gold_ready,
        output run, ns, l_sel, gold_load, sym_idx, busy, sf_done, err
    );

    modport master (
        output sf_start, sf_num, nrs_subframe, cinit_done, gold_ready,
        input  run, ns, l_sel, gold_load, sym_idx, busy, sf_done, err
    );
endinterface

// File: rtl/nrs_cinit_scheduler.sv
// nrs_cinit_scheduler
//   Per-subframe sequencer for the NRS cinit datapath. On an accepted
//   subframe start it issues four cinit computations in the order
//   (2sf,l5), (2sf,l6), (2sf+1,l5), (2sf+1,l6); after each one it waits for
//   cinit_done and then hands the result to the Gold generator through the
//   gold_ready/gold_load handshake.
//   Ports:
//     clk  : system clock, rising edge
//     rst  : asynchronous active-low reset
//     bus  : scheduler side of nrs_cinit_scheduler_if (see interface file)
//   Parameter:
//     TIMEOUT : maximum cycles spent waiting for cinit_done before abort
module nrs_cinit_scheduler #(
    parameter int unsigned TIMEOUT = 32
) (
    input logic                        clk,
    input logic                        rst,
    nrs_cinit_scheduler_if.slave       bus
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        WAIT_CINIT,
        WAIT_GOLD,
        DONE
    } state_t;

    state_t          state_q, state_d;
    logic [4:0]      base_q, base_d;
    logic [1:0]      sym_q, sym_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            err_q, err_d;
    logic            load;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            base_q  <= '0;
            sym_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            sym_q   <= sym_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        sym_d   = sym_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        load    = (state_q == WAIT_GOLD) && bus.gold_ready;

        case (state_q)
            IDLE: begin
                // Starts without NRS are dropped silently; a bad subframe
                // number is only flagged when the subframe claims NRS.
                if (bus.sf_start && bus.nrs_subframe) begin
                    if (bus.sf_num <= 4'd9) begin
                        state_d = RUN;
                        base_d  = {bus.sf_num, 1'b0};
                        sym_d   = '0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            RUN: begin
                state_d = WAIT_CINIT;
                cnt_d   = '0;
            end
            WAIT_CINIT: begin
                cnt_d = cnt_q + 1'b1;
                if (bus.cinit_done) begin
                    state_d = WAIT_GOLD;
                    cnt_d   = cnt_q;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    // This is the TIMEOUT-th cycle without a result.
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            WAIT_GOLD: begin
                if (load) begin
                    if (sym_q == 2'd3) begin
                        state_d = DONE;
                    end else begin
                        sym_d   = sym_q + 2'd1;
                        state_d = RUN;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Overrun; ORed so it merges with a same-cycle timeout.
        if (bus.sf_start && (state_q != IDLE)) begin
            err_d = 1'b1;
        end
    end

    assign bus.run       = (state_q == RUN);
    assign bus.busy      = (state_q != IDLE);
    assign bus.sf_done   = (state_q == DONE);
    assign bus.gold_load = load;
    assign bus.err       = err_q;
    assign bus.sym_idx   = sym_q;
    assign bus.l_sel     = sym_q[0];
    assign bus.ns        = base_q + {4'd0, sym_q[1]};

endmodule

// File: tb/tb_nrs_cinit_scheduler.sv
module tb_nrs_cinit_scheduler;

    localparam int TMO = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;

    nrs_cinit_scheduler_if bus ();

    nrs_cinit_scheduler #(.TIMEOUT(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        n_chk++;
        if (a === e) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, a, a, e, e);
    endtask

    function automatic logic [12:0] pk(input logic run, input logic [4:0] ns, input logic l,
                                       input logic gl, input logic [1:0] sym, input logic busy,
                                       input logic done, input logic err);
        return {run, ns, l, gl, sym, busy, done, err};
    endfunction

    function automatic logic [12:0] dut_v();
        return pk(bus.run, bus.ns, bus.l_sel, bus.gold_load, bus.sym_idx,
                  bus.busy, bus.sf_done, bus.err);
    endfunction

    // ---------------- event logs (filled by the monitor) ----------------
    int run_q[$], run_ns[$], run_l[$], run_sym[$];
    int load_q[$], load_ns[$], load_l[$];
    int done_q[$], err_q[$], cd_q[$];

    function automatic int at(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -999;
    endfunction

    // ---------------- reference model + monitor ----------------
    // Subframe progress is tracked as timestamps: the cycle of the current
    // run, whether its cinit has arrived, and the cycle sf_done is due.
    bit         m_act = 0;
    bit         m_got = 0;
    bit         m_err = 0;
    int         m_k = 0;
    int         m_run_at = -1;
    int         m_done_at = -1;
    logic [4:0] m_base = '0;

    initial begin
        logic [4:0]  e_ns;
        logic [12:0] e_v;
        bit          e_n;
        forever begin
            @(negedge clk);
            if (!rst) begin
                m_act = 0; m_got = 0; m_err = 0; m_k = 0;
                m_run_at = -1; m_done_at = -1; m_base = '0;
            end
            e_ns = m_base + 5'(m_k / 2);
            e_v  = pk(m_act && (cyc == m_run_at), e_ns, 1'(m_k % 2),
                      m_act && m_got && bus.gold_ready, 2'(m_k), m_act,
                      m_act && (cyc == m_done_at), m_err);
            chk($sformatf("model@%0d", cyc), 32'(dut_v()), 32'(e_v));
            if (rst) begin
                if (bus.run)        begin run_q.push_back(cyc); run_ns.push_back(int'(bus.ns));
                                          run_l.push_back(int'(bus.l_sel)); run_sym.push_back(int'(bus.sym_idx)); end
                if (bus.gold_load)  begin load_q.push_back(cyc); load_ns.push_back(int'(bus.ns));
                                          load_l.push_back(int'(bus.l_sel)); end
                if (bus.sf_done)    done_q.push_back(cyc);
                if (bus.err)        err_q.push_back(cyc);
                if (bus.cinit_done) cd_q.push_back(cyc);

                e_n = 0;
                if (m_act) begin
                    if (bus.sf_start) e_n = 1;
                    if (cyc == m_done_at) begin
                        m_act = 0;
                    end else if (m_got) begin
                        if (bus.gold_ready) begin
                            m_got = 0;
                            if (m_k < 3) begin m_k++; m_run_at = cyc + 1; end
                            else m_done_at = cyc + 1;
                        end
                    end else if (m_done_at < 0 && cyc > m_run_at) begin
                        if (bus.cinit_done) m_got = 1;
                        else if (cyc - m_run_at == TMO) begin e_n = 1; m_act = 0; end
                    end
                end else if (bus.sf_start && bus.nrs_subframe) begin
                    if (bus.sf_num <= 9) begin
                        m_act = 1; m_got = 0; m_k = 0; m_base = 5'(2 * bus.sf_num);
                        m_run_at = cyc + 1; m_done_at = -1;
                    end else begin
                        e_n = 1;
                    end
                end
                m_err = e_n;
            end
        end
    end

    // ---------------- responder (driven from the main process) ----------------
    int resp_mode = 0;      // 0: manual, 1: fixed latency, 2: random
    int lat = 7;
    int withhold = -1;      // run index whose cinit_done is never returned
    int gr_block = -1;      // cinit_done index after which gold_ready drops for 10 cycles
    int resp_runs = 0, resp_cds = 0, cd_at = -1, gr_low_until = -1, mute = 0;

    task automatic step();
        @(posedge clk);
        #1;
        if (!rst) begin cd_at = -1; gr_low_until = -1; end
        if (resp_mode == 1) begin
            if (run_q.size() > resp_runs) begin
                resp_runs++;
                cd_at = (resp_runs - 1 == withhold) ? -1 : run_q[$] + lat;
            end
            bus.cinit_done = (cyc == cd_at);
            if (bus.cinit_done) begin
                resp_cds++;
                if (resp_cds - 1 == gr_block) gr_low_until = cyc + 10;
            end
            bus.gold_ready = (cyc > gr_low_until);
        end else if (resp_mode == 2) begin
            if (mute > 0) mute--;
            else if ($urandom_range(149) == 0) mute = 40;
            bus.cinit_done = (mute == 0) && ($urandom_range(2) == 0);
            bus.gold_ready = 1'($urandom_range(1));
        end
    endtask

    task automatic clear_logs();
        run_q.delete(); run_ns.delete(); run_l.delete(); run_sym.delete();
        load_q.delete(); load_ns.delete(); load_l.delete();
        done_q.delete(); err_q.delete(); cd_q.delete();
        resp_runs = 0; resp_cds = 0; cd_at = -1; gr_low_until = -1;
    endtask

    task automatic start_sf(input logic [3:0] num, input logic nrs);
        bus.sf_start = 1'b1; bus.sf_num = num; bus.nrs_subframe = nrs;
        step();
        bus.sf_start = 1'b0; bus.sf_num = '0; bus.nrs_subframe = 1'b0;
    endtask

    function automatic int ev_cnt(input int which);
        case (which)
            0:       return run_q.size();
            1:       return done_q.size();
            default: return err_q.size();
        endcase
    endfunction

    task automatic wait_ev(input int which, input int n, input int budget, input string nm);
        int k = 0;
        while (ev_cnt(which) < n && k < budget) begin step(); k++; end
        chk(nm, 32'(ev_cnt(which) >= n), 32'd1);
    endtask

    task automatic check_seq(input string tag, input int base);
        chk({tag, "_runs"},  32'(run_q.size()),  32'd4);
        chk({tag, "_loads"}, 32'(load_q.size()), 32'd4);
        chk({tag, "_dones"}, 32'(done_q.size()), 32'd1);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("%s_ns%0d", tag, i),  32'(at(run_ns, i)),  32'(base + i / 2));
            chk($sformatf("%s_l%0d", tag, i),   32'(at(run_l, i)),   32'(i % 2));
            chk($sformatf("%s_sym%0d", tag, i), 32'(at(run_sym, i)), 32'(i));
        end
        chk({tag, "_done_after_load"}, 32'(at(done_q, 0) - at(load_q, 3)), 32'd1);
    endtask

    // ---------------- table-driven vectors ----------------
    typedef struct {
        logic        st;
        logic [3:0]  num;
        logic        nrs;
        logic        cd;
        logic        gr;
        logic [12:0] exp;
    } vec_t;

    function automatic vec_t mk(input logic st, input logic [3:0] num, input logic nrs,
                                input logic cd, input logic gr, input logic run,
                                input logic [4:0] ns, input logic l, input logic [1:0] sym,
                                input logic gl, input logic busy, input logic done,
                                input logic err);
        vec_t v;
        v.st = st; v.num = num; v.nrs = nrs; v.cd = cd; v.gr = gr;
        v.exp = pk(run, ns, l, gl, sym, busy, done, err);
        return v;
    endfunction

    vec_t tbl[20];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ov;
        //           st num nrs cd gr | run ns l sym gl busy done err
        tbl[0]  = mk(1, 2, 1, 0, 1,     0, 0, 0, 0, 0, 0, 0, 0);
        tbl[1]  = mk(0, 0, 0, 0, 1,     1, 4, 0, 0, 0, 1, 0, 0);
        tbl[2]  = mk(0, 0, 0, 1, 1,     0, 4, 0, 0, 0, 1, 0, 0);
        tbl[3]  = mk(0, 0, 0, 0, 1,     0, 4, 0, 0, 1, 1, 0, 0);
        tbl[4]  = mk(0, 0, 0, 0, 1,     1, 4, 1, 1, 0, 1, 0, 0);
        tbl[5]  = mk(0, 0, 0, 1, 1,     0, 4, 1, 1, 0, 1, 0, 0);
        tbl[6]  = mk(0, 0, 0, 0, 0,     0, 4, 1, 1, 0, 1, 0, 0);
        tbl[7]  = mk(0, 0, 0, 0, 1,     0, 4, 1, 1, 1, 1, 0, 0);
        tbl[8]  = mk(0, 0, 0, 0, 1,     1, 5, 0, 2, 0, 1, 0, 0);
        tbl[9]  = mk(0, 0, 0, 1, 1,     0, 5, 0, 2, 0, 1, 0, 0);
        tbl[10] = mk(0, 0, 0, 0, 1,     0, 5, 0, 2, 1, 1, 0, 0);
        tbl[11] = mk(0, 0, 0, 0, 1,     1, 5, 1, 3, 0, 1, 0, 0);
        tbl[12] = mk(0, 0, 0, 1, 1,     0, 5, 1, 3, 0, 1, 0, 0);
        tbl[13] = mk(0, 0, 0, 0, 1,     0, 5, 1, 3, 1, 1, 0, 0);
        tbl[14] = mk(1, 1, 1, 0, 1,     0, 5, 1, 3, 0, 1, 1, 0);
        tbl[15] = mk(0, 0, 0, 0, 1,     0, 5, 1, 3, 0, 0, 0, 1);
        tbl[16] = mk(1, 3, 0, 0, 1,     0, 5, 1, 3, 0, 0, 0, 0);
        tbl[17] = mk(1, 10, 1, 0, 1,    0, 5, 1, 3, 0, 0, 0, 0);
        tbl[18] = mk(0, 0, 0, 0, 1,     0, 5, 1, 3, 0, 0, 0, 1);
        tbl[19] = mk(0, 0, 0, 1, 1,     0, 5, 1, 3, 0, 0, 0, 0);

        bus.sf_start = 1'b0; bus.sf_num = '0; bus.nrs_subframe = 1'b0;
        bus.cinit_done = 1'b0; bus.gold_ready = 1'b0;

        // Reset values
        rst = 1'b0;
        step(); step();
        chk("reset_vals", 32'(dut_v()), 32'd0);
        rst = 1'b1;

        // Table: short sequence, Gold backpressure, DONE-cycle overrun, filtered starts
        for (int i = 0; i < 20; i++) begin
            bus.sf_start = tbl[i].st; bus.sf_num = tbl[i].num; bus.nrs_subframe = tbl[i].nrs;
            bus.cinit_done = tbl[i].cd; bus.gold_ready = tbl[i].gr;
            @(negedge clk);
            chk($sformatf("vec%0d", i), 32'(dut_v()), 32'(tbl[i].exp));
            step();
        end
        bus.sf_start = 1'b0; bus.nrs_subframe = 1'b0; bus.sf_num = '0; bus.cinit_done = 1'b0;
        resp_mode = 1;
        repeat (3) step();

        // Nominal subframe, sf_num=3, latency 7
        clear_logs(); lat = 7; withhold = -1; gr_block = -1;
        start_sf(4'd3, 1'b1);
        wait_ev(1, 1, 100, "nom_wait_done");
        repeat (3) step();
        check_seq("nom", 6);
        chk("nom_first_load", 32'(at(load_q, 0) - at(run_q, 0)), 32'd8);
        chk("nom_total", 32'(at(done_q, 0) - at(run_q, 0)), 32'd36);
        chk("nom_no_err", 32'(err_q.size()), 32'd0);

        // Backpressure after the 2nd cinit_done, sf_num=9
        clear_logs(); gr_block = 1;
        start_sf(4'd9, 1'b1);
        wait_ev(1, 1, 120, "bp_wait_done");
        repeat (3) step();
        check_seq("bp", 18);
        chk("bp_load_delay", 32'(at(load_q, 1) - at(cd_q, 1)), 32'd11);
        chk("bp_next_run", 32'(at(run_q, 2) - at(load_q, 1)), 32'd1);
        chk("bp_load_ns", 32'(at(load_ns, 1)), 32'd18);
        chk("bp_load_l", 32'(at(load_l, 1)), 32'd1);
        gr_block = -1;

        // Overrun during the 2nd WAIT_CINIT
        clear_logs();
        start_sf(4'd4, 1'b1);
        wait_ev(0, 2, 60, "ov_wait_run2");
        step();
        ov = cyc;
        start_sf(4'd5, 1'b1);
        wait_ev(1, 1, 100, "ov_wait_done");
        repeat (3) step();
        check_seq("ov", 8);
        chk("ov_err_cnt", 32'(err_q.size()), 32'd1);
        chk("ov_err_cyc", 32'(at(err_q, 0)), 32'(ov + 1));

        // Timeout on the 3rd symbol
        clear_logs(); withhold = 2;
        start_sf(4'd1, 1'b1);
        wait_ev(2, 1, 150, "tmo_wait_err");
        chk("tmo_err_delay", 32'(at(err_q, 0) - at(run_q, 2)), 32'd33);
        chk("tmo_runs", 32'(run_q.size()), 32'd3);
        chk("tmo_busy", 32'(bus.busy), 32'd0);
        repeat (5) step();
        chk("tmo_no_done", 32'(done_q.size()), 32'd0);
        clear_logs(); withhold = -1;
        start_sf(4'd2, 1'b1);
        wait_ev(1, 1, 100, "tmo_restart_done");
        repeat (3) step();
        check_seq("tmo_restart", 4);

        // Reset during the 3rd WAIT_CINIT
        clear_logs();
        start_sf(4'd7, 1'b1);
        wait_ev(0, 3, 80, "rst_wait_run3");
        step();
        rst = 1'b0;
        #1;
        chk("rst_async_zero", 32'(dut_v()), 32'd0);
        step(); step();
        rst = 1'b1;
        clear_logs();
        repeat (40) step();
        chk("rst_no_err", 32'(err_q.size()), 32'd0);
        chk("rst_no_done", 32'(done_q.size()), 32'd0);
        start_sf(4'd0, 1'b1);
        wait_ev(1, 1, 100, "rst_restart_done");
        repeat (3) step();
        check_seq("rst_restart", 0);

        // Random traffic against the model
        resp_mode = 2;
        repeat (3000) begin
            step();
            bus.sf_start     = ($urandom_range(24) == 0);
            bus.sf_num       = 4'($urandom_range(11));
            bus.nrs_subframe = ($urandom_range(3) != 0);
            rst              = ($urandom_range(999) != 0);
        end
        step();
        rst = 1'b1; bus.sf_start = 1'b0;
        repeat (60) step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
